// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: oversample tick generation, idle-line arming,
// and a small byte FIFO between the receiver and its consumer.
module uart_rx_ctrl #(
  parameter int N       = 8,
  parameter int DEPTH   = 4,
  parameter int IDLE_TK = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [15:0]                baud_div,
  input  logic                       rx,
  input  logic                       rx_done,
  input  logic [N-1:0]               rx_data,
  output logic                       sample_tick,
  output logic                       rx_hold,
  output logic                       m_valid,
  output logic [N-1:0]               m_data,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overrun,
  input  logic                       clr_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (IDLE_TK > 1) ? $clog2(IDLE_TK) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TK - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic [1:0] {
    OFF = 2'd0,
    ARM = 2'd1,
    RUN = 2'd2
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [15:0]     cnt;
  logic [IW-1:0]   idle_cnt;
  logic [IW-1:0]   idle_d;
  logic            tick_on;
  logic            rx_done_q;

  logic [N-1:0]    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            push;
  logic            pop;
  logic            wr_en;
  logic            drop;

  assign tick_on     = (state != OFF);
  assign sample_tick = tick_on && (cnt >= baud_div);
  assign rx_hold     = (state != RUN);

  // Tick counter; the >= compare absorbs a baud_div decrease.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!tick_on || sample_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // State, idle run-length and rx_done edge register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OFF;
      idle_cnt  <= '0;
      rx_done_q <= 1'b0;
    end else begin
      state     <= state_d;
      idle_cnt  <= idle_d;
      rx_done_q <= rx_done;
    end
  end

  // Next state: arm on enable, release after IDLE_TK idle ticks.
  always_comb begin
    state_d = state;
    idle_d  = idle_cnt;
    unique case (state)
      OFF: begin
        if (en) begin
          state_d = ARM;
          idle_d  = '0;
        end
      end
      ARM: begin
        if (sample_tick) begin
          if (!rx) begin
            idle_d = '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state_d = RUN;
          end else begin
            idle_d = idle_cnt + 1'b1;
          end
        end
      end
      RUN: begin
      end
      default: begin
        state_d = OFF;
      end
    endcase
    if (!en) begin
      state_d = OFF;
    end
  end

  assign full       = (count == FULL_CNT);
  assign m_valid    = (count != '0);
  assign m_data     = mem[rd_ptr];
  assign fifo_count = count;
  assign pop        = m_valid && m_ready;
  assign push       = (state == RUN) && rx_done && !rx_done_q;
  assign wr_en      = push && (!full || pop);
  assign drop       = push && full && !pop;

  // FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !wr_en) begin
        count <= count - 1'b1;
      end
    end
  end

  // Sticky overrun; a drop beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus a random phase,
// all outputs compared each cycle against a queue-based model.
module tb_uart_rx_ctrl;

  localparam int N       = 8;
  localparam int DEPTH   = 4;
  localparam int IDLE_TK = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [15:0] baud_div = 16'd0;
  logic        rx = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        m_ready = 1'b0;
  logic        clr_overrun = 1'b0;

  logic        sample_tick;
  logic        rx_hold;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [2:0]  fifo_count;
  logic        overrun;

  uart_rx_ctrl #(.N(N), .DEPTH(DEPTH), .IDLE_TK(IDLE_TK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .baud_div    (baud_div),
    .rx          (rx),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .sample_tick (sample_tick),
    .rx_hold     (rx_hold),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .fifo_count  (fifo_count),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: line mode, cycles since last tick, idle run length,
  // byte queue and sticky drop flag.
  typedef enum {DOWN, WAIT, LIVE} mode_t;
  mode_t      md = DOWN;
  int         since = 0;
  int         ones = 0;
  logic [7:0] q[$];
  bit         ovr = 0;
  bit         done_prev = 0;

  function automatic bit m_tick();
    return (md != DOWN) && (since >= int'(baud_div));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md = DOWN;
      since = 0;
      ones = 0;
      q.delete();
      ovr = 0;
      done_prev = 0;
    end else begin
      bit t;
      bit pp;
      bit ps;
      int sz;
      t  = m_tick();
      sz = q.size();
      pp = (sz > 0) && m_ready;
      ps = (md == LIVE) && rx_done && !done_prev;
      if (pp) void'(q.pop_front());
      if (ps && (sz < DEPTH || pp)) q.push_back(rx_data);
      if (ps && sz == DEPTH && !pp) ovr = 1;
      else if (clr_overrun) ovr = 0;
      done_prev = rx_done;
      since = (md == DOWN || t) ? 0 : since + 1;
      if (!en) md = DOWN;
      else if (md == DOWN) begin
        md = WAIT;
        ones = 0;
      end else if (md == WAIT && t) begin
        ones = rx ? ones + 1 : 0;
        if (ones == IDLE_TK) md = LIVE;
      end
    end
  end

  task automatic check_all();
    chk("tick", sample_tick, m_tick());
    chk("hold", rx_hold, md != LIVE);
    chk("valid", m_valid, q.size() != 0);
    chk("count", fifo_count, q.size());
    chk("ovr", overrun, ovr);
    if (q.size() != 0) chk("data", m_data, q[0]);
  endtask

  bit rand_on = 0;

  task automatic drive_random();
    if ($urandom_range(99) == 0) en = ~en;
    rx          = ($urandom_range(99) < 97);
    rx_done     = ($urandom_range(99) < 30);
    rx_data     = 8'($urandom);
    m_ready     = ($urandom_range(99) < 40);
    clr_overrun = ($urandom_range(99) < 4);
    if ($urandom_range(199) == 0) baud_div = 16'($urandom_range(5));
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
      if (rand_on) drive_random();
    end
  endtask

  task automatic push_byte(logic [7:0] d);
    rx_data = d;
    rx_done = 1'b1;
    step(1);
    rx_done = 1'b0;
    step(1);
  endtask

  logic [7:0] exp4 [4];
  logic [7:0] exp5 [4];

  initial begin
    exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;
    exp5[0] = 8'h22; exp5[1] = 8'h33; exp5[2] = 8'h44; exp5[3] = 8'h66;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_hold", rx_hold, 1);
    chk("rst_tick", sample_tick, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovr", overrun, 0);
    step(2);
    rst_n = 1'b1;

    // idle-line release at baud_div=3, then disable
    baud_div = 16'd3;
    rx = 1'b1;
    en = 1'b1;
    step(80);
    chk("t1_run", rx_hold, 0);
    en = 1'b0;
    step(1);
    chk("t1_off_tick", sample_tick, 0);
    chk("t1_off_hold", rx_hold, 1);
    step(3);

    // low rx during arming restarts the idle count
    en = 1'b1;
    step(40);
    rx = 1'b0;
    step(8);
    rx = 1'b1;
    step(40);
    chk("t2_still_held", rx_hold, 1);
    step(40);
    chk("t2_released", rx_hold, 0);

    // long rx_done gives a single entry
    m_ready = 1'b0;
    rx_data = 8'hA5;
    rx_done = 1'b1;
    step(3);
    rx_done = 1'b0;
    step(1);
    chk("t3_count", fifo_count, 1);
    chk("t3_valid", m_valid, 1);
    chk("t3_data", m_data, 8'hA5);
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
    chk("t3_empty", fifo_count, 0);

    // overfill, drain, clear
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    push_byte(8'h55);
    chk("t4_count", fifo_count, 4);
    chk("t4_ovr", overrun, 1);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain", m_data, exp4[i]);
      step(1);
    end
    m_ready = 1'b0;
    chk("t4_empty", fifo_count, 0);
    clr_overrun = 1'b1;
    step(1);
    clr_overrun = 1'b0;
    chk("t4_clr", overrun, 0);

    // push into a full FIFO together with a pop
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    rx_data = 8'h66;
    rx_done = 1'b1;
    m_ready = 1'b1;
    step(1);
    rx_done = 1'b0;
    m_ready = 1'b0;
    step(1);
    chk("t5_count", fifo_count, 4);
    chk("t5_ovr", overrun, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_drain", m_data, exp5[i]);
      step(1);
    end
    m_ready = 1'b0;

    // asynchronous reset with entries pending
    push_byte(8'hC1);
    push_byte(8'hC2);
    chk("t6_pre", fifo_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", m_valid, 0);
    chk("t6_count", fifo_count, 0);
    chk("t6_hold", rx_hold, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    push_byte(8'h77);
    push_byte(8'h78);
    chk("t6_ignored", fifo_count, 0);

    // random phase
    baud_div = 16'd1;
    rand_on = 1;
    step(6000);
    rand_on = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
